// File: rtl/iob_uart16550_txstream.sv
// Byte-stream transmit front end for the UART16550: programs the core over its IOb
// slave port once, then feeds THR in bursts gated by an LSR.THRE credit counter.
module iob_uart16550_txstream #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                               clk_i,
   input  logic                               cke_i,
   input  logic                               arst_n_i,
   input  logic                               init_i,
   input  logic [15:0]                        div_i,
   output logic                               init_done_o,
   output logic                               busy_o,
   input  logic [7:0]                         s_tdata_i,
   input  logic                               s_tvalid_i,
   output logic                               s_tready_o,
   output logic                               iob_avalid_o,
   output logic [ADDR_W-1:0]                  iob_addr_o,
   output logic [DATA_W-1:0]                  iob_wdata_o,
   output logic [DATA_W/8-1:0]                iob_wstrb_o,
   input  logic                               iob_ready_i,
   input  logic                               iob_rvalid_i,
   input  logic [DATA_W-1:0]                  iob_rdata_i,
   output logic [3:0]                         dbg_state_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbg_credit_o
);

   localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
   localparam int STRB_W   = DATA_W / 8;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_CFG0  = 4'd1;
   localparam logic [3:0] ST_CFG1  = 4'd2;
   localparam logic [3:0] ST_CFG2  = 4'd3;
   localparam logic [3:0] ST_CFG3  = 4'd4;
   localparam logic [3:0] ST_CFG4  = 4'd5;
   localparam logic [3:0] ST_POLL  = 4'd6;
   localparam logic [3:0] ST_PWAIT = 4'd7;
   localparam logic [3:0] ST_SEND  = 4'd8;
   localparam logic [3:0] ST_WR    = 4'd9;

   localparam logic [ADDR_W-1:0] ADDR_THR = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_DLL = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_DLM = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_FCR = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_LCR = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_LSR = ADDR_W'(5);

   logic [3:0]          state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [15:0]         div_q, div_d;
   logic                done_d;
   logic                avalid_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [STRB_W-1:0]   wstrb_d;
   logic                req_en, req_wr;
   logic [ADDR_W-1:0]   req_addr;
   logic [7:0]          req_byte;
   logic                bus_accept;
   logic [7:0]          lsr_byte;
   logic                lsr_unused;

   // Handshakes: a stream byte moves when s_tvalid_i & s_tready_o; an IOb request
   // moves when iob_avalid_o & iob_ready_i and is held stable until then.
   assign bus_accept = iob_avalid_o & iob_ready_i;

   function automatic logic [STRB_W-1:0] lane_strb(input logic [ADDR_W-1:0] a);
      logic [STRB_W-1:0] s;
      s = '0;
      for (int i = 0; i < STRB_W; i++) s[i] = (a[1:0] == 2'(i));
      return s;
   endfunction

   always_comb begin
      lsr_byte = 8'h00;
      for (int i = 0; i < STRB_W; i++)
         if (iob_addr_o[1:0] == 2'(i)) lsr_byte = iob_rdata_i[8*i +: 8];
   end

   assign lsr_unused = ^{lsr_byte[7:6], lsr_byte[4:0]};

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      div_d    = div_q;
      done_d   = init_done_o;
      req_en   = 1'b0;
      req_wr   = 1'b1;
      req_addr = ADDR_THR;
      req_byte = 8'h00;
      case (state_q)
         ST_IDLE: if (init_i) begin
            div_d    = div_i;
            state_d  = ST_CFG0;
            req_en   = 1'b1;
            req_addr = ADDR_LCR;
            req_byte = 8'h83;
         end
         ST_CFG0: if (bus_accept) begin
            state_d  = ST_CFG1;
            req_en   = 1'b1;
            req_addr = ADDR_DLL;
            req_byte = div_q[7:0];
         end
         ST_CFG1: if (bus_accept) begin
            state_d  = ST_CFG2;
            req_en   = 1'b1;
            req_addr = ADDR_DLM;
            req_byte = div_q[15:8];
         end
         ST_CFG2: if (bus_accept) begin
            state_d  = ST_CFG3;
            req_en   = 1'b1;
            req_addr = ADDR_LCR;
            req_byte = 8'h03;
         end
         ST_CFG3: if (bus_accept) begin
            state_d  = ST_CFG4;
            req_en   = 1'b1;
            req_addr = ADDR_FCR;
            req_byte = 8'h07;
         end
         ST_CFG4: if (bus_accept) begin
            state_d  = ST_SEND;
            done_d   = 1'b1;
            credit_d = '0;
         end
         ST_SEND: begin
            if (credit_q != '0) begin
               if (s_tvalid_i) begin
                  state_d  = ST_WR;
                  req_en   = 1'b1;
                  req_addr = ADDR_THR;
                  req_byte = s_tdata_i;
               end
            end else if (s_tvalid_i) begin
               // Only spend bus bandwidth on LSR polls when there is data to send.
               state_d  = ST_POLL;
               req_en   = 1'b1;
               req_wr   = 1'b0;
               req_addr = ADDR_LSR;
            end
         end
         ST_WR: if (bus_accept) begin
            credit_d = credit_q - CREDIT_W'(1);
            state_d  = ST_SEND;
         end
         ST_POLL: if (bus_accept) state_d = ST_PWAIT;
         ST_PWAIT: if (iob_rvalid_i) begin
            if (lsr_byte[5]) begin
               credit_d = CREDIT_W'(FIFO_DEPTH);
               state_d  = ST_SEND;
            end else begin
               state_d  = ST_POLL;
               req_en   = 1'b1;
               req_wr   = 1'b0;
               req_addr = ADDR_LSR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      avalid_d = iob_avalid_o & ~iob_ready_i;
      addr_d   = iob_addr_o;
      wdata_d  = iob_wdata_o;
      wstrb_d  = iob_wstrb_o;
      if (req_en) begin
         avalid_d = 1'b1;
         addr_d   = req_addr;
         wdata_d  = {STRB_W{req_byte}};
         wstrb_d  = req_wr ? lane_strb(req_addr) : '0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q      <= ST_IDLE;
         credit_q     <= '0;
         div_q        <= '0;
         init_done_o  <= 1'b0;
         iob_avalid_o <= 1'b0;
         iob_addr_o   <= '0;
         iob_wdata_o  <= '0;
         iob_wstrb_o  <= '0;
      end else if (cke_i) begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         div_q        <= div_d;
         init_done_o  <= done_d;
         iob_avalid_o <= avalid_d;
         iob_addr_o   <= addr_d;
         iob_wdata_o  <= wdata_d;
         iob_wstrb_o  <= wstrb_d;
      end
   end

   // Ready is a pure function of state and credit so upstream never sees a loop.
   assign s_tready_o   = (state_q == ST_SEND) && (credit_q != '0);
   assign busy_o       = !((state_q == ST_IDLE) || (state_q == ST_SEND));
   assign dbg_state_o  = state_q;
   assign dbg_credit_o = credit_q;

endmodule
